// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader driving the main memory write port.
// Frame: SYNC, start address, length (0 = 256), payload, checksum.
module prog_loader #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_val,
    output logic       mem_set,
    output logic       mem_get,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CSUM
    } state_t;

    // Idle count at which the next stalled cycle trips the timeout.
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  ptr;
    logic [8:0]  cnt;
    logic [7:0]  acc;
    logic [15:0] tcnt;
    logic        xfer;
    logic [7:0]  sum;

    assign xfer    = in_valid && in_ready;
    assign sum     = acc + in_data;
    assign mem_get = 1'b0;

    // Frame sequencer: parses the stream, issues writes, tracks checksum and idle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            mem_addr <= '0;
            mem_val  <= '0;
            mem_set  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            acc      <= '0;
            tcnt     <= '0;
        end else begin
            in_ready <= 1'b1;
            mem_set  <= 1'b0;
            done     <= 1'b0;
            if (state == IDLE) begin
                tcnt <= '0;
                if (xfer && in_data == SYNC) begin
                    state <= ADDR;
                    busy  <= 1'b1;
                    err   <= 1'b0;
                end
            end else if (xfer) begin
                tcnt <= '0;
                case (state)
                    ADDR: begin
                        ptr   <= in_data;
                        acc   <= in_data;
                        state <= LEN;
                    end
                    LEN: begin
                        cnt   <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        acc   <= sum;
                        state <= DATA;
                    end
                    DATA: begin
                        mem_addr <= ptr;
                        mem_val  <= in_data;
                        mem_set  <= 1'b1;
                        acc      <= sum;
                        ptr      <= ptr + 8'd1;
                        cnt      <= cnt - 9'd1;
                        if (cnt == 9'd1) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (sum == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (tcnt == TLAST) begin
                tcnt  <= '0;
                busy  <= 1'b0;
                err   <= 1'b1;
                state <= IDLE;
            end else begin
                tcnt <= tcnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a write scoreboard and memory model.
module tb_prog_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_val;
    logic       mem_set;
    logic       mem_get;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  fq[$];
    logic [7:0]  mem[256];

    int n_set  = 0;
    int n_done = 0;
    int n_busy = 0;
    logic done_prev = 1'b0;

    prog_loader #(.SYNC(8'hA5), .TIMEOUT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_val  (mem_val),
        .mem_set  (mem_set),
        .mem_get  (mem_get),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: stores at the edge following the strobe cycle
    always @(posedge clk) begin
        if (mem_set) mem[mem_addr] <= mem_val;
    end

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_set) begin
                n_set++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected: got addr=%02h val=%02h, expected no write", mem_addr, mem_val);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_val} !== e) begin
                        failures++;
                        $display("FAIL write_data: got addr=%02h val=%02h, expected addr=%02h val=%02h",
                                 mem_addr, mem_val, e[15:8], e[7:0]);
                    end
                end
            end
            if (done) n_done++;
            if (busy) n_busy++;
            checks++;
            if ((done && err) || (done && done_prev) || mem_get !== 1'b0) begin
                failures++;
                $display("FAIL pulse_rules: done=%b done_prev=%b err=%b mem_get=%b, expected no done+err, single-cycle done, mem_get=0",
                         done, done_prev, err, mem_get);
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic send_fq(input int stall);
        for (int i = 0; i < fq.size(); i++) begin
            if (stall > 0 && i > 0) begin
                in_valid = 1'b0;
                repeat (stall) @(posedge clk);
                #1;
            end
            in_data  = fq[i];
            in_valid = 1'b1;
            begin
                int w;
                w = 0;
                while (!in_ready && w < 16) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (w == 16) begin
                    checks++;
                    failures++;
                    $display("FAIL in_ready_wait: got in_ready=0 for 16 cycles, expected 1");
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic settle;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL writes_missing: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic push_basic;
        exp_q.push_back(16'h1011);
        exp_q.push_back(16'h1122);
        exp_q.push_back(16'h1233);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_addr, mem_val, mem_set, busy, done, err} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b a=%02h v=%02h set=%b busy=%b done=%b err=%b, expected all 0",
                     in_ready, mem_addr, mem_val, mem_set, busy, done, err);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int s0, d0;
        s0 = n_set; d0 = n_done; n_busy = 0;
        push_basic();
        fq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_fq(0);
        settle();
        checks++;
        if (n_set - s0 != 3 || n_done - d0 != 1 || err !== 1'b0 || n_busy != 6) begin
            failures++;
            $display("FAIL basic_frame: got sets=%0d dones=%0d err=%b busy_cycles=%0d, expected 3 1 0 6",
                     n_set - s0, n_done - d0, err, n_busy);
        end
        checks++;
        if (mem[8'h10] !== 8'h11 || mem[8'h11] !== 8'h22 || mem[8'h12] !== 8'h33) begin
            failures++;
            $display("FAIL basic_mem: got %02h %02h %02h, expected 11 22 33", mem[8'h10], mem[8'h11], mem[8'h12]);
        end
    endtask

    task automatic test_wrap_garbage;
        int d0;
        d0 = n_done; n_busy = 0;
        fq = '{8'h00, 8'hFF};
        send_fq(0);
        @(posedge clk);
        #1;
        checks++;
        if (n_busy != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL garbage_busy: got busy_cycles=%0d busy=%b, expected 0 0", n_busy, busy);
        end
        exp_q.push_back(16'hFE01);
        exp_q.push_back(16'hFF02);
        exp_q.push_back(16'h0003);
        fq = '{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF9};
        send_fq(0);
        settle();
        checks++;
        if (n_done - d0 != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done: got dones=%0d err=%b, expected 1 0", n_done - d0, err);
        end
    endtask

    task automatic test_len256;
        int s0, d0, bad;
        s0 = n_set; d0 = n_done; bad = 0;
        fq = '{8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) begin
            fq.push_back(8'(i));
            exp_q.push_back({8'(i), 8'(i)});
        end
        fq.push_back(8'h80);
        send_fq(0);
        settle();
        checks++;
        if (n_set - s0 != 256 || n_done - d0 != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL len256: got sets=%0d dones=%0d err=%b, expected 256 1 0", n_set - s0, n_done - d0, err);
        end
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== 8'(i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL len256_mem: got %0d wrong locations, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_data;
        int d0;
        exp_q.push_back(16'h1011);
        exp_q.push_back(16'h1122);
        fq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22};
        send_fq(0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_addr, mem_val, mem_set, busy, done, err} !== 22'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got rdy=%b a=%02h v=%02h set=%b busy=%b done=%b err=%b, expected all 0",
                     in_ready, mem_addr, mem_val, mem_set, busy, done, err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem[8'h12] !== 8'h12 || mem[8'h11] !== 8'h22 || exp_q.size() != 0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mem: got m12=%02h m11=%02h pending=%0d err=%b, expected 12 22 0 0",
                     mem[8'h12], mem[8'h11], exp_q.size(), err);
        end
        d0 = n_done;
        push_basic();
        fq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_fq(0);
        settle();
        checks++;
        if (n_done - d0 != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_recover: got dones=%0d err=%b, expected 1 0", n_done - d0, err);
        end
    endtask

    task automatic test_bad_csum;
        int d0;
        d0 = n_done;
        push_basic();
        fq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
        send_fq(0);
        settle();
        checks++;
        if (err !== 1'b1 || n_done != d0 || mem[8'h12] !== 8'h33) begin
            failures++;
            $display("FAIL bad_csum: got err=%b dones=%0d m12=%02h, expected 1 0 33", err, n_done - d0, mem[8'h12]);
        end
        fq = '{8'hA5};
        send_fq(0);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_clear_at_sync: got err=%b busy=%b, expected 0 1", err, busy);
        end
        push_basic();
        fq = '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_fq(0);
        settle();
        checks++;
        if (n_done - d0 != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL good_after_bad: got dones=%0d err=%b, expected 1 0", n_done - d0, err);
        end
    endtask

    task automatic test_timeout;
        int s0, d0;
        s0 = n_set; d0 = n_done;
        fq = '{8'hA5, 8'h10};
        send_fq(0);
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got busy=%b err=%b after 7 idle, expected 1 0", busy, err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || n_set != s0 || n_done != d0) begin
            failures++;
            $display("FAIL timeout_fire: got busy=%b err=%b sets=%0d dones=%0d, expected 0 1 0 0",
                     busy, err, n_set - s0, n_done - d0);
        end
        d0 = n_done;
        push_basic();
        fq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_fq(7);
        settle();
        checks++;
        if (n_done - d0 != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL stall7_frame: got dones=%0d err=%b, expected 1 0", n_done - d0, err);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_wrap_garbage();
        test_len256();
        test_reset_mid_data();
        test_bad_csum();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader sitting directly upstream of the 256×8 main memory. It accepts framed bytes (sync, start address, length, payload, checksum) on a valid/ready input and drives the memory's write port (`addr`, `val`, `set`) to deposit the payload at consecutive addresses. It raises `busy` while a frame is in progress so the CPU control unit can be held off. It reports `done` or `err` at frame end.

## Interface
- `SYNC`, default 8'hA5: frame start byte.
- `TIMEOUT`, default 255: idle-cycle limit inside a frame; legal range 1..65535.
- `clk`  in  1  rising-edge clock shared with memory.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_ready`  out  1  loader accepts a byte; transfer occurs when `in_valid && in_ready` at a rising edge.
- `mem_addr`  out  8  to memory `addr`.
- `mem_val`  out  8  to memory `val`.
- `mem_set`  out  1  to memory `set`; one-cycle write strobe.
- `mem_get`  out  1  to memory `get`; constant 0.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse: frame completed with a good checksum.
- `err`  out  1  sticky: last frame failed.

## Operation
- **Reset values**, asynchronous while `rst_n`=0: state IDLE, `in_ready`=0, `mem_addr`=0, `mem_val`=0, `mem_set`=0, `busy`=0, `done`=0, `err`=0, all counters 0. `in_ready` is 1 in every state after reset release.
- **States:** IDLE → ADDR → LEN → DATA → CSUM → IDLE.
  - IDLE: an accepted byte equal to `SYNC` → ADDR and clears `err`. Any other byte is discarded.
  - ADDR: accepted byte loads the write pointer and seeds the checksum accumulator (`acc` = byte) → LEN.
  - LEN: accepted byte loads the remaining count; 0 means 256. `acc += byte` → DATA.
  - DATA: each accepted byte is written to memory at the pointer. Then `acc += byte`, pointer increments mod 256 (0xFF wraps to 0x00), count decrements. When the last byte is accepted → CSUM.
  - CSUM: accepted byte `c`.
    - If `(acc + c) mod 256 == 0`: pulse `done`.
    - Otherwise set `err`.
    - Either way → IDLE.
- **Arithmetic:** `acc` is 8-bit, wrapping. The count register is 9-bit so that 256 is representable.
- **Memory writes** are not deferred until the checksum is checked. On a bad checksum, bytes already written remain in memory.
- **`busy`** is 1 in ADDR, LEN, DATA and CSUM, and 0 in IDLE.
- **Timeout:** a 16-bit counter runs in every non-IDLE state.
  - It clears on each accepted byte and increments on each cycle with no transfer.
  - When it reaches `TIMEOUT`, the loader returns to IDLE with `err`=1 and `done`=0.
- **SYNC outside IDLE:** a byte equal to `SYNC` received in any state other than IDLE is ordinary data. Frames do not resynchronise mid-frame.
- **Reset mid-frame** aborts the frame immediately. No further `mem_set` occurs, and `err` is not set.

## Timing
- A data byte accepted at edge k drives `mem_addr`, `mem_val` and `mem_set`=1 during the cycle after edge k. The memory stores it at edge k+1.
- `mem_set` is low in every cycle that does not follow a DATA acceptance.
- Back-to-back valid bytes are accepted every cycle. Sustained rate is 1 write per cycle with no bubbles.
- `done` and the `err` set are registered at the edge that accepts the CSUM byte. `busy` falls at the same edge.
- A timeout fires at the edge where the idle count reaches `TIMEOUT`, i.e. after `TIMEOUT` consecutive non-transfer cycles. `err` and `busy`=0 are visible in the following cycle.
- `err` clears at the edge that accepts the next `SYNC` in IDLE.
- `done` is never high for more than one cycle. `done` and a newly set `err` never assert together.

## Test plan
- **Basic frame:** stream A5 10 03 11 22 33 87 back-to-back. Required: memory[0x10..0x12]=11,22,33; exactly 3 `mem_set` pulses; `done` pulse; `err`=0; `busy` high for 6 cycles.
- **Wrap and leading garbage:** stream 00 FF A5 FE 03 01 02 03 F9.
  - The first two bytes are ignored with no `busy`.
  - Writes land at FE, FF, 00 with values 01, 02, 03.
  - `done` pulses.
- **Length 0 (256 bytes):** A5 00 00, then data 00..FF, then checksum 80. Required: 256 writes, memory[i]=i for all i, `done` pulse.
- **Bad checksum:** basic frame with last byte 88. Required: memory[0x10..0x12] written; `err`=1 sticky; no `done`. A following good frame clears `err` at its SYNC and ends with `done`.
- **Timeout** (`TIMEOUT`=8): A5 10, then `in_valid`=0.
  - `err`=1 and `busy`=0 after the 8th idle cycle; no `mem_set`.
  - With `TIMEOUT`=8 and 7-cycle stalls between bytes of the basic frame: `done`, no `err`.
- **Reset mid-DATA:** assert `rst_n`=0 after 11 22 of the basic frame. Required: all outputs at reset values immediately; memory[0x12] unchanged; after release, a fresh basic frame completes with `done`.
